// File: rtl/rgb_cmp_pwm.sv
// ============================================================================
// Module   : rgb_cmp_pwm
// Purpose  : Clocked RGB magnitude comparator with double-buffered PWM drive.
//            Optional macro RGB_FADE_EN ramps active duty one step per frame.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_cmp_pwm #(
  parameter int WIDTH  = 2,
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [DUTY_W-1:0] duty,
  output logic              red,
  output logic              green,
  output logic              blue,
  output logic              frame,
  output logic              valid
);

  localparam logic [0:0]        ST_OFF  = 1'b0;
  localparam logic [0:0]        ST_ON   = 1'b1;
  localparam logic [DUTY_W-1:0] CNT_MAX = '1;

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [2:0]        shadow_sel_q, shadow_sel_d;
  logic [DUTY_W-1:0] shadow_duty_q, shadow_duty_d;
  logic              pending_q, pending_d;
  logic [2:0]        active_sel_q, active_sel_d;
  logic [DUTY_W-1:0] active_duty_q, active_duty_d;
  logic [0:0]        state_q, state_d;
  logic [2:0]        rgb_q, rgb_d;
  logic              frame_q, frame_d;

  logic              w_boundary;
  logic [2:0]        w_cmp_sel;
`ifdef RGB_FADE_EN
  logic [DUTY_W-1:0] w_fade_base;
  logic [DUTY_W-1:0] w_fade_next;
`endif

  always_comb begin
    cnt_d         = en ? cnt_q + 1'b1 : '0;
    w_boundary    = en && (cnt_q == CNT_MAX);
    w_cmp_sel     = (a > b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);

    shadow_sel_d  = shadow_sel_q;
    shadow_duty_d = shadow_duty_q;
    pending_d     = pending_q;
    active_sel_d  = active_sel_q;
    active_duty_d = active_duty_q;
    state_d       = state_q;
`ifdef RGB_FADE_EN
    // A colour change restarts the ramp from zero so the new colour fades in.
    w_fade_base   = (active_sel_q != shadow_sel_q) ? '0 : active_duty_q;
    if (w_fade_base < shadow_duty_q) begin
      w_fade_next = w_fade_base + 1'b1;
    end else if (w_fade_base > shadow_duty_q) begin
      w_fade_next = w_fade_base - 1'b1;
    end else begin
      w_fade_next = w_fade_base;
    end
`endif

    if (w_boundary && pending_q) begin
      state_d      = ST_ON;
      active_sel_d = shadow_sel_q;
`ifdef RGB_FADE_EN
      active_duty_d = w_fade_next;
      pending_d     = (w_fade_next != shadow_duty_q);
`else
      active_duty_d = shadow_duty_q;
      pending_d     = 1'b0;
`endif
    end

    // A load on the boundary cycle lands in shadow after the old shadow was applied.
    if (load) begin
      shadow_sel_d  = w_cmp_sel;
      shadow_duty_d = duty;
      pending_d     = 1'b1;
    end

    rgb_d   = ((state_q == ST_ON) && en && (cnt_q < active_duty_q)) ? active_sel_q : 3'b000;
    frame_d = w_boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      shadow_sel_q  <= '0;
      shadow_duty_q <= '0;
      pending_q     <= 1'b0;
      active_sel_q  <= '0;
      active_duty_q <= '0;
      state_q       <= ST_OFF;
      rgb_q         <= '0;
      frame_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      shadow_sel_q  <= shadow_sel_d;
      shadow_duty_q <= shadow_duty_d;
      pending_q     <= pending_d;
      active_sel_q  <= active_sel_d;
      active_duty_q <= active_duty_d;
      state_q       <= state_d;
      rgb_q         <= rgb_d;
      frame_q       <= frame_d;
    end
  end

  assign red   = rgb_q[2];
  assign green = rgb_q[1];
  assign blue  = rgb_q[0];
  assign frame = frame_q;
  assign valid = (state_q == ST_ON);

endmodule

`default_nettype wire
